// File: rtl/draw_pkg.sv
// Shared encodings and default geometry for the rectangle rasteriser.
package draw_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAW   = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic MODE_FILL    = 1'b0;
  localparam logic MODE_OUTLINE = 1'b1;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;
  localparam int DEF_X_W      = 8;
  localparam int DEF_Y_W      = 7;
  localparam int DEF_COL_W    = 3;

endpackage

// File: rtl/draw_rect_raster_scan.sv
// Row-major cursor over a clipped rectangle; with load asserted the cursor is
// taken straight from the load bounds so the first pixel can go out immediately.
module raster_scan
  import draw_pkg::*;
#(
  parameter int X_W = DEF_X_W,
  parameter int Y_W = DEF_Y_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           advance,
  input  logic           outline,
  input  logic [X_W-1:0] ld_x0,
  input  logic [X_W-1:0] ld_xe,
  input  logic [Y_W-1:0] ld_y0,
  input  logic [Y_W-1:0] ld_ye,
  output logic [X_W-1:0] cur_x,
  output logic [Y_W-1:0] cur_y,
  output logic           last
);

  logic [X_W-1:0] x0_r, xe_r, x_r;
  logic [Y_W-1:0] y0_r, ye_r, y_r;
  logic           outline_r;

  logic [X_W-1:0] bx0_s, bxe_s, nx_s;
  logic [Y_W-1:0] by0_s, bye_s, ny_s;
  logic           bout_s;

  // Cursor/bounds view for this cycle and its successor pixel.
  always_comb begin
    bx0_s  = load ? ld_x0 : x0_r;
    bxe_s  = load ? ld_xe : xe_r;
    by0_s  = load ? ld_y0 : y0_r;
    bye_s  = load ? ld_ye : ye_r;
    bout_s = load ? outline : outline_r;
    cur_x  = load ? ld_x0 : x_r;
    cur_y  = load ? ld_y0 : y_r;
    last   = (cur_x == bxe_s) && (cur_y == bye_s);
    nx_s   = cur_x;
    ny_s   = cur_y;
    if (cur_x == bxe_s) begin
      nx_s = bx0_s;
      ny_s = cur_y + Y_W'(1);
    end else if (bout_s && (cur_y != by0_s) && (cur_y != bye_s) && (cur_x == bx0_s)) begin
      // interior outline rows only touch the two edge columns
      nx_s = bxe_s;
    end else begin
      nx_s = cur_x + X_W'(1);
    end
  end

  // Bounds capture and cursor stepping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x0_r      <= '0;
      xe_r      <= '0;
      y0_r      <= '0;
      ye_r      <= '0;
      x_r       <= '0;
      y_r       <= '0;
      outline_r <= 1'b0;
    end else begin
      if (load) begin
        x0_r      <= ld_x0;
        xe_r      <= ld_xe;
        y0_r      <= ld_y0;
        ye_r      <= ld_ye;
        outline_r <= outline;
      end
      if (advance) begin
        x_r <= nx_s;
        y_r <= ny_s;
      end else if (load) begin
        x_r <= cur_x;
        y_r <= cur_y;
      end
    end
  end

endmodule

// File: rtl/draw_rect.sv
// Rectangle rasteriser: clips the request to the screen and streams one pixel
// per cycle (filled or outline) to the VGA pixel-write port.
module draw_rect
  import draw_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int X_W      = DEF_X_W,
  parameter int Y_W      = DEF_Y_W,
  parameter int COL_W    = DEF_COL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [X_W-1:0]   x0,
  input  logic [Y_W-1:0]   y0,
  input  logic [X_W-1:0]   w,
  input  logic [Y_W-1:0]   h,
  input  logic [COL_W-1:0] col_in,
  input  logic             stall,
  output logic             plot,
  output logic [X_W-1:0]   x_out,
  output logic [Y_W-1:0]   y_out,
  output logic [COL_W-1:0] col_out,
  output logic             busy,
  output logic             done
);

  localparam logic [X_W:0] SW_EXT = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SH_EXT = (Y_W+1)'(SCREEN_H);

  state_t           state_r, state_s;
  logic             end_r, end_s;
  logic [COL_W-1:0] col_r;

  logic [X_W:0]     xsum_s, xlim_s, xm1_s;
  logic [Y_W:0]     ysum_s, ylim_s, ym1_s;
  logic [X_W-1:0]   xe_s;
  logic [Y_W-1:0]   ye_s;
  logic             degen_s;

  logic             load_s, advance_s, last_s;
  logic [X_W-1:0]   cur_x_s;
  logic [Y_W-1:0]   cur_y_s;

  logic             plot_s, busy_s, done_s;
  logic [X_W-1:0]   x_s;
  logic [Y_W-1:0]   y_s;
  logic [COL_W-1:0] col_s;

  // Clip the request; one extra bit on the sums keeps x0+w from wrapping.
  always_comb begin
    xsum_s = {1'b0, x0} + {1'b0, w};
    ysum_s = {1'b0, y0} + {1'b0, h};
    if (xsum_s > SW_EXT) xlim_s = SW_EXT;
    else                 xlim_s = xsum_s;
    if (ysum_s > SH_EXT) ylim_s = SH_EXT;
    else                 ylim_s = ysum_s;
    xm1_s   = xlim_s - (X_W+1)'(1);
    ym1_s   = ylim_s - (Y_W+1)'(1);
    xe_s    = xm1_s[X_W-1:0];
    ye_s    = ym1_s[Y_W-1:0];
    degen_s = (w == '0) || (h == '0) || ({1'b0, x0} >= SW_EXT) || ({1'b0, y0} >= SH_EXT);
  end

  raster_scan #(
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_scan (
    .clk     (clk),
    .reset   (reset),
    .load    (load_s),
    .advance (advance_s),
    .outline (mode == MODE_OUTLINE),
    .ld_x0   (x0),
    .ld_xe   (xe_s),
    .ld_y0   (y0),
    .ld_ye   (ye_s),
    .cur_x   (cur_x_s),
    .cur_y   (cur_y_s),
    .last    (last_s)
  );

  // Next state and next output values.
  always_comb begin
    state_s   = state_r;
    end_s     = end_r;
    load_s    = 1'b0;
    advance_s = 1'b0;
    plot_s    = 1'b0;
    busy_s    = busy;
    done_s    = 1'b0;
    x_s       = x_out;
    y_s       = y_out;
    col_s     = col_out;
    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
        end_s  = 1'b0;
        if (start) begin
          busy_s = 1'b1;
          if (degen_s) begin
            state_s = FINISH;
            done_s  = 1'b1;
          end else begin
            state_s = DRAW;
            load_s  = 1'b1;
            if (!stall) begin
              advance_s = 1'b1;
              plot_s    = 1'b1;
              x_s       = cur_x_s;
              y_s       = cur_y_s;
              col_s     = col_in;
              end_s     = last_s;
            end else begin
              plot_s = 1'b0;
            end
          end
        end else begin
          state_s = IDLE;
        end
      end
      DRAW: begin
        if (end_r) begin
          // the cycle after the final pixel carries the done pulse
          state_s = FINISH;
          done_s  = 1'b1;
          end_s   = 1'b0;
        end else if (!stall) begin
          advance_s = 1'b1;
          plot_s    = 1'b1;
          x_s       = cur_x_s;
          y_s       = cur_y_s;
          col_s     = col_r;
          end_s     = last_s;
        end else begin
          plot_s = 1'b0;
        end
      end
      FINISH: begin
        state_s = IDLE;
        busy_s  = 1'b0;
        end_s   = 1'b0;
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
        end_s   = 1'b0;
      end
    endcase
  end

  // State, request colour and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      end_r   <= 1'b0;
      col_r   <= '0;
      plot    <= 1'b0;
      x_out   <= '0;
      y_out   <= '0;
      col_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_s;
      end_r   <= end_s;
      if (load_s) col_r <= col_in;
      plot    <= plot_s;
      x_out   <= x_s;
      y_out   <= y_s;
      col_out <= col_s;
      busy    <= busy_s;
      done    <= done_s;
    end
  end

endmodule

// File: tb/tb_draw_rect.sv
// Randomised bench for draw_rect against a pixel-list model built from the
// rectangle rules (clip, fill/outline membership, row-major order).
module tb_draw_rect;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] x0 = '0;
  logic [6:0] y0 = '0;
  logic [7:0] w = '0;
  logic [6:0] h = '0;
  logic [2:0] col_in = '0;
  logic       stall = 1'b0;
  logic       plot, busy, done;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] col_out;

  int errors = 0;
  int checks = 0;
  int last_x = 0, last_y = 0, last_c = 0;

  draw_rect dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .x0(x0), .y0(y0), .w(w), .h(h), .col_in(col_in), .stall(stall),
    .plot(plot), .x_out(x_out), .y_out(y_out), .col_out(col_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic scramble_inputs();
    x0 = 8'($urandom); y0 = 7'($urandom); w = 8'($urandom); h = 7'($urandom);
    col_in = 3'($urandom); mode = 1'($urandom);
  endtask

  task automatic run_req(input int ax0, input int ay0, input int aw, input int ah,
                         input int ac, input int am, input int stall_pct,
                         input int stall_from, input bit stall0, input bit spurious,
                         output int n_plots, output int done_cyc);
    int ex[$];
    int ey[$];
    int xe, ye, n, idx, cyc, exp_done;
    bit degen, prev_stall, exp_plot, finished;
    degen = (aw == 0) || (ah == 0) || (ax0 >= 160) || (ay0 >= 120);
    xe = ((ax0 + aw > 160) ? 160 : ax0 + aw) - 1;
    ye = ((ay0 + ah > 120) ? 120 : ay0 + ah) - 1;
    if (!degen) begin
      for (int yy = ay0; yy <= ye; yy++)
        for (int xx = ax0; xx <= xe; xx++)
          if (am == 0 || yy == ay0 || yy == ye || xx == ax0 || xx == xe) begin
            ex.push_back(xx);
            ey.push_back(yy);
          end
    end
    n = ex.size();
    n_plots = 0;
    done_cyc = -1;
    idx = 0;
    exp_done = degen ? 1 : -1;
    finished = 1'b0;

    @(negedge clk);
    x0 = 8'(ax0); y0 = 7'(ay0); w = 8'(aw); h = 7'(ah);
    col_in = 3'(ac); mode = 1'(am); start = 1'b1;
    stall = stall0 || (int'($urandom_range(99)) < stall_pct);
    prev_stall = stall;
    @(posedge clk); #1;
    start = 1'b0;
    scramble_inputs();
    cyc = 1;
    while (!finished && cyc < 60000) begin
      if (cyc == exp_done) begin
        check("done_pulse", done, 1);
        check("done_plot", plot, 0);
        check("done_busy", busy, 1);
        done_cyc = cyc;
        start = 1'b0;
        stall = 1'b0;
        @(posedge clk); #1;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        finished = 1'b1;
      end else begin
        check("done_low", done, 0);
        check("busy_high", busy, 1);
        exp_plot = !prev_stall && (idx < n);
        check("plot", plot, int'(exp_plot));
        n_plots += int'(plot);
        if (exp_plot) begin
          last_x = ex[idx]; last_y = ey[idx]; last_c = ac;
          idx++;
          if (idx == n) exp_done = cyc + 1;
        end
        check("x_out", x_out, last_x);
        check("y_out", y_out, last_y);
        check("col_out", col_out, last_c);
        stall = (stall_from > 0 && cyc >= stall_from && cyc < stall_from + 3)
                || (int'($urandom_range(99)) < stall_pct);
        prev_stall = stall;
        if (spurious && $urandom_range(7) == 0) begin
          scramble_inputs();
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!finished) check("timeout", 0, 1);
    start = 1'b0;
    stall = 1'b0;
  endtask

  int np, dc;

  initial begin
    #12;
    check("rst_plot", plot, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_x", x_out, 0);
    check("rst_y", y_out, 0);
    check("rst_col", col_out, 0);
    @(negedge clk);
    reset = 1'b0;

    run_req(10, 20, 4, 3, 5, 0, 0, 0, 1'b0, 1'b0, np, dc);
    check("fill_n", np, 12);
    check("fill_done", dc, 13);
    run_req(10, 20, 4, 3, 6, 1, 0, 0, 1'b0, 1'b0, np, dc);
    check("outline_n", np, 10);
    check("outline_done", dc, 11);
    run_req(158, 119, 5, 4, 2, 0, 0, 0, 1'b0, 1'b0, np, dc);
    check("clip_n", np, 2);
    check("clip_done", dc, 3);
    run_req(30, 30, 0, 5, 1, 0, 0, 0, 1'b0, 1'b0, np, dc);
    check("degen_n", np, 0);
    check("degen_done", dc, 1);
    run_req(5, 5, 1, 4, 3, 1, 0, 0, 1'b0, 1'b0, np, dc);
    check("col1_n", np, 4);
    run_req(10, 20, 4, 3, 7, 0, 0, 4, 1'b0, 1'b1, np, dc);
    check("stall_n", np, 12);
    check("stall_done", dc, 16);
    run_req(40, 40, 3, 2, 4, 0, 0, 0, 1'b1, 1'b0, np, dc);
    check("startstall_n", np, 6);
    check("startstall_done", dc, 8);
    run_req(0, 0, 160, 120, 0, 0, 0, 0, 1'b0, 1'b0, np, dc);
    check("clear_n", np, 19200);
    check("clear_done", dc, 19201);

    for (int i = 0; i < 40; i++) begin
      run_req(int'($urandom_range(170)), int'($urandom_range(127)),
              int'($urandom_range(24)), int'($urandom_range(16)),
              int'($urandom_range(7)), int'($urandom_range(1)),
              30, 0, 1'($urandom), 1'($urandom), np, dc);
    end

    // asynchronous reset in the middle of a draw
    @(negedge clk);
    x0 = 8'd0; y0 = 7'd0; w = 8'd160; h = 7'd120; col_in = 3'd3; mode = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_plot", plot, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_x", x_out, 0);
    check("arst_y", y_out, 0);
    @(negedge clk);
    reset = 1'b0;
    last_x = 0; last_y = 0; last_c = 0;
    run_req(3, 4, 2, 2, 5, 0, 0, 0, 1'b0, 1'b0, np, dc);
    check("post_rst_n", np, 4);
    check("post_rst_done", dc, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
